branch_predictor: RTL and testbench

Direct-mapped branch target buffer with 2-bit saturating direction counters. Sits beside the IF stage: it looks up the fetch PC and produces the `Find`/`Pred_take` flags and predicted target that travel down IF/ID and ID/EX. It is also the endpoint for those flags. The EX stage returns the resolved outcome to it, and the block trains its tables and raises the mispredict redirect.

---
 rtl/branch_predictor_pkg.sv | 25 ++
 rtl/bp_counter_table.sv | 36 +++
 rtl/branch_predictor.sv | 114 +++++++++++
 tb/tb_branch_predictor.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: 2-bit direction counter
// encoding and the saturating counter update.
package branch_predictor_pkg;

  localparam logic [1:0] CTR_SNT   = 2'b00;
  localparam logic [1:0] CTR_WNT   = 2'b01;
  localparam logic [1:0] CTR_WT    = 2'b10;
  localparam logic [1:0] CTR_ST    = 2'b11;
  localparam logic [1:0] CTR_RESET = CTR_WNT;
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

  // Saturating step toward the resolved direction; never wraps 11<->00.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      if (ctr == CTR_ST) nxt = CTR_ST;
      else               nxt = ctr + 2'd1;
    end else begin
      if (ctr == CTR_SNT) nxt = CTR_SNT;
      else                nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Table of 2-bit direction counters: one read port for fetch lookup,
// one read port for EX resolve, and one write port for training.
module bp_counter_table
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] a_idx,
  output logic [1:0]       a_ctr,
  input  logic [IDX_W-1:0] b_idx,
  output logic [1:0]       b_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [1:0]       wr_ctr
);

  logic [1:0] ctr_r [ENTRIES];

  // Counter storage: reset to weak not-taken, single write per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_r[i] <= CTR_RESET;
      end
    end else if (wr_en) begin
      ctr_r[wr_idx] <= wr_ctr;
    end
  end

  assign a_ctr = ctr_r[a_idx];
  assign b_ctr = ctr_r[b_idx];

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: combinational fetch
// lookup, EX-stage mispredict detection and table training.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int TAG_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] IF_pc,
  output logic        IF_Find,
  output logic        IF_Pred_take,
  output logic [63:0] IF_pred_target,
  input  logic        EX_update,
  input  logic [63:0] EX_pc,
  input  logic        EX_taken,
  input  logic [63:0] EX_target,
  input  logic        EX_Find,
  input  logic        EX_Pred_take,
  output logic        EX_mispredict,
  output logic [63:0] EX_redirect_pc
);

  localparam int IDX    = $clog2(ENTRIES);
  localparam int TAG_LO = IDX + 2;
  localparam int TAG_HI = IDX + TAG_BITS + 1;

  logic                valid_r  [ENTRIES];
  logic [TAG_BITS-1:0] tag_r    [ENTRIES];
  logic [63:0]         target_r [ENTRIES];

  logic [IDX-1:0]      if_idx_s;
  logic [IDX-1:0]      ex_idx_s;
  logic [TAG_BITS-1:0] if_tag_s;
  logic [TAG_BITS-1:0] ex_tag_s;
  logic [1:0]          if_ctr_s;
  logic [1:0]          ex_ctr_s;
  logic                if_hit_s;
  logic                ex_hit_s;
  logic                ex_hit_tgt_s;
  logic                ctr_wr_en_s;
  logic [1:0]          ctr_wr_val_s;

  assign if_idx_s = IF_pc[IDX+1:2];
  assign ex_idx_s = EX_pc[IDX+1:2];
  assign if_tag_s = IF_pc[TAG_HI:TAG_LO];
  assign ex_tag_s = EX_pc[TAG_HI:TAG_LO];

  bp_counter_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX)
  ) u_ctr_table (
    .clk    (clk),
    .rst    (rst),
    .a_idx  (if_idx_s),
    .a_ctr  (if_ctr_s),
    .b_idx  (ex_idx_s),
    .b_ctr  (ex_ctr_s),
    .wr_en  (ctr_wr_en_s),
    .wr_idx (ex_idx_s),
    .wr_ctr (ctr_wr_val_s)
  );

  assign if_hit_s     = valid_r[if_idx_s] && (tag_r[if_idx_s] == if_tag_s);
  assign ex_hit_s     = valid_r[ex_idx_s] && (tag_r[ex_idx_s] == ex_tag_s);
  assign ex_hit_tgt_s = ex_hit_s && (target_r[ex_idx_s] == EX_target);

  assign IF_Find        = if_hit_s;
  assign IF_Pred_take   = if_hit_s & if_ctr_s[1];
  assign IF_pred_target = if_hit_s ? target_r[if_idx_s] : (IF_pc + 64'd4);

  // Target check catches partial-tag aliasing; a spurious flush is harmless.
  assign EX_mispredict  = EX_update &
                          ((EX_taken != (EX_Find & EX_Pred_take)) |
                           (EX_taken & EX_Pred_take & ~ex_hit_tgt_s));
  assign EX_redirect_pc = EX_taken ? EX_target : (EX_pc + 64'd4);

  // Counter write: step on a tag hit, allocate weak-taken on a taken miss.
  always_comb begin
    ctr_wr_en_s  = 1'b0;
    ctr_wr_val_s = ex_ctr_s;
    case ({EX_update, ex_hit_s, EX_taken})
      3'b110, 3'b111: begin
        ctr_wr_en_s  = 1'b1;
        ctr_wr_val_s = sat_update(ex_ctr_s, EX_taken);
      end
      3'b101: begin
        ctr_wr_en_s  = 1'b1;
        ctr_wr_val_s = CTR_ALLOC;
      end
      default: begin
        ctr_wr_en_s  = 1'b0;
        ctr_wr_val_s = ex_ctr_s;
      end
    endcase
  end

  // BTB valid/tag/target arrays; a taken resolve always refreshes the target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= '0;
        target_r[i] <= 64'd0;
      end
    end else if (EX_update && EX_taken) begin
      valid_r[ex_idx_s]  <= 1'b1;
      tag_r[ex_idx_s]    <= ex_tag_s;
      target_r[ex_idx_s] <= EX_target;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor (ENTRIES=16, TAG_BITS=10).
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [63:0] IF_pc;
  logic        IF_Find;
  logic        IF_Pred_take;
  logic [63:0] IF_pred_target;
  logic        EX_update;
  logic [63:0] EX_pc;
  logic        EX_taken;
  logic [63:0] EX_target;
  logic        EX_Find;
  logic        EX_Pred_take;
  logic        EX_mispredict;
  logic [63:0] EX_redirect_pc;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic        upd;
    logic [63:0] ex_pc;
    logic        taken;
    logic [63:0] ex_tgt;
    logic        find;
    logic        pred;
    logic [63:0] if_pc;
    logic        e_find;
    logic        e_pred;
    logic [63:0] e_tgt;
    logic        e_misp;
    logic [63:0] e_redir;
    logic        chk_redir;
  } vec_t;

  vec_t vecs[$];

  branch_predictor #(.ENTRIES(16), .TAG_BITS(10)) dut (
    .clk            (clk),
    .rst            (rst),
    .IF_pc          (IF_pc),
    .IF_Find        (IF_Find),
    .IF_Pred_take   (IF_Pred_take),
    .IF_pred_target (IF_pred_target),
    .EX_update      (EX_update),
    .EX_pc          (EX_pc),
    .EX_taken       (EX_taken),
    .EX_target      (EX_target),
    .EX_Find        (EX_Find),
    .EX_Pred_take   (EX_Pred_take),
    .EX_mispredict  (EX_mispredict),
    .EX_redirect_pc (EX_redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t v(input logic upd, input logic [63:0] ex_pc, input logic taken,
                             input logic [63:0] ex_tgt, input logic find, input logic pred,
                             input logic [63:0] if_pc, input logic e_find, input logic e_pred,
                             input logic [63:0] e_tgt, input logic e_misp,
                             input logic [63:0] e_redir, input logic chk_redir);
    vec_t r;
    r.upd = upd; r.ex_pc = ex_pc; r.taken = taken; r.ex_tgt = ex_tgt;
    r.find = find; r.pred = pred; r.if_pc = if_pc; r.e_find = e_find;
    r.e_pred = e_pred; r.e_tgt = e_tgt; r.e_misp = e_misp;
    r.e_redir = e_redir; r.chk_redir = chk_redir;
    return r;
  endfunction

  initial begin
    // Each row is one cycle: lookup/resolve outputs reflect pre-update state.
    vecs.push_back(v(1'b0, 64'h0,     1'b0, 64'h0,    1'b0, 1'b0, 64'h1000, 1'b0, 1'b0, 64'h1004, 1'b0, 64'h0,    1'b0)); // reset
    vecs.push_back(v(1'b1, 64'h1000,  1'b1, 64'h1200, 1'b0, 1'b0, 64'h1000, 1'b0, 1'b0, 64'h1004, 1'b1, 64'h1200, 1'b1)); // cold alloc, collision
    vecs.push_back(v(1'b1, 64'h1000,  1'b0, 64'h1200, 1'b1, 1'b1, 64'h1000, 1'b1, 1'b1, 64'h1200, 1'b1, 64'h1004, 1'b1)); // 10->01
    vecs.push_back(v(1'b1, 64'h1000,  1'b0, 64'h1200, 1'b1, 1'b0, 64'h1000, 1'b1, 1'b0, 64'h1200, 1'b0, 64'h1004, 1'b1)); // 01->00
    vecs.push_back(v(1'b1, 64'h1000,  1'b0, 64'h1200, 1'b1, 1'b0, 64'h1000, 1'b1, 1'b0, 64'h1200, 1'b0, 64'h1004, 1'b1)); // 00 sat
    vecs.push_back(v(1'b1, 64'h1000,  1'b1, 64'h1200, 1'b1, 1'b0, 64'h1000, 1'b1, 1'b0, 64'h1200, 1'b1, 64'h1200, 1'b1)); // 00->01
    vecs.push_back(v(1'b1, 64'h1000,  1'b1, 64'h1200, 1'b1, 1'b0, 64'h1000, 1'b1, 1'b0, 64'h1200, 1'b1, 64'h1200, 1'b1)); // 01->10
    vecs.push_back(v(1'b1, 64'h1000,  1'b1, 64'h1200, 1'b1, 1'b1, 64'h1000, 1'b1, 1'b1, 64'h1200, 1'b0, 64'h1200, 1'b1)); // 10->11
    vecs.push_back(v(1'b1, 64'h1000,  1'b1, 64'h1200, 1'b1, 1'b1, 64'h1000, 1'b1, 1'b1, 64'h1200, 1'b0, 64'h1200, 1'b1)); // 11 sat, correct
    vecs.push_back(v(1'b1, 64'h1000,  1'b0, 64'h1200, 1'b1, 1'b1, 64'h1000, 1'b1, 1'b1, 64'h1200, 1'b1, 64'h1004, 1'b1)); // 11->10
    vecs.push_back(v(1'b0, 64'h1000,  1'b1, 64'h9990, 1'b0, 1'b0, 64'h1000, 1'b1, 1'b1, 64'h1200, 1'b0, 64'h0,    1'b0)); // bubble
    vecs.push_back(v(1'b1, 64'h11000, 1'b1, 64'h3000, 1'b0, 1'b0, 64'h11000,1'b1, 1'b1, 64'h1200, 1'b1, 64'h3000, 1'b1)); // alias overwrite
    vecs.push_back(v(1'b1, 64'h1000,  1'b1, 64'h1200, 1'b1, 1'b1, 64'h1000, 1'b1, 1'b1, 64'h3000, 1'b1, 64'h1200, 1'b1)); // alias target check
    vecs.push_back(v(1'b0, 64'h0,     1'b0, 64'h0,    1'b0, 1'b0, 64'h1000, 1'b1, 1'b1, 64'h1200, 1'b0, 64'h0,    1'b0)); // target restored
    vecs.push_back(v(1'b1, 64'h2004,  1'b0, 64'h2100, 1'b0, 1'b0, 64'h2004, 1'b0, 1'b0, 64'h2008, 1'b0, 64'h2008, 1'b1)); // NT miss
    vecs.push_back(v(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h40, 1'b0, 1'b0,
                     64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1));                                        // pc+4 wrap
    vecs.push_back(v(1'b0, 64'h0,     1'b0, 64'h0,    1'b0, 1'b0, 64'h2004, 1'b0, 1'b0, 64'h2008, 1'b0, 64'h0,    1'b0)); // no NT alloc

    rst = 1'b0; IF_pc = 64'h0; EX_update = 1'b0; EX_pc = 64'h0; EX_taken = 1'b0;
    EX_target = 64'h0; EX_Find = 1'b0; EX_Pred_take = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      EX_update = vecs[i].upd; EX_pc = vecs[i].ex_pc; EX_taken = vecs[i].taken;
      EX_target = vecs[i].ex_tgt; EX_Find = vecs[i].find; EX_Pred_take = vecs[i].pred;
      IF_pc = vecs[i].if_pc;
      #1;
      chk($sformatf("v%0d find", i),  {63'd0, IF_Find},       {63'd0, vecs[i].e_find});
      chk($sformatf("v%0d pred", i),  {63'd0, IF_Pred_take},  {63'd0, vecs[i].e_pred});
      chk($sformatf("v%0d tgt", i),   IF_pred_target,         vecs[i].e_tgt);
      chk($sformatf("v%0d misp", i),  {63'd0, EX_mispredict}, {63'd0, vecs[i].e_misp});
      if (vecs[i].chk_redir) chk($sformatf("v%0d redir", i), EX_redirect_pc, vecs[i].e_redir);
    end

    // Asynchronous reset with a pending allocation: entry 0x1000 vanishes at once,
    // and the update held across the reset edge must not land.
    @(negedge clk);
    EX_update = 1'b1; EX_pc = 64'h2008; EX_taken = 1'b1; EX_target = 64'h4000;
    EX_Find = 1'b0; EX_Pred_take = 1'b0; IF_pc = 64'h1000;
    #1;
    chk("pre_rst find", {63'd0, IF_Find}, 64'd1);
    #1 rst = 1'b0;
    #1;
    chk("async_rst find", {63'd0, IF_Find}, 64'd0);
    chk("async_rst tgt", IF_pred_target, 64'h1004);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; EX_update = 1'b0; IF_pc = 64'h2008;
    #1;
    chk("rst_discard find", {63'd0, IF_Find}, 64'd0);
    chk("rst_discard tgt", IF_pred_target, 64'h200C);
    chk("rst misp", {63'd0, EX_mispredict}, 64'd0);
    IF_pc = 64'h1000;
    #1;
    chk("post_rst pred", {63'd0, IF_Pred_take}, 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
